// File: rtl/magnitude_detector_pkg.sv
// Shared types and sizing helpers for the magnitude detector.
package magnitude_detector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2
    } det_state_t;

    // Running sum width: one extra bit per doubling of the window keeps it overflow-free.
    function automatic int sum_width(input int width, input int log2_len);
        return width + log2_len;
    endfunction

endpackage

// File: rtl/magnitude_window.sv
// Boxcar moving average over the last 2^LOG2_LEN accepted magnitude samples.
module magnitude_window
    import magnitude_detector_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LOG2_LEN = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] mag,
    input  logic             ivalid,
    input  logic             clear,
    output logic [WIDTH-1:0] avg,
    output logic             ovalid,
    output logic [WIDTH-1:0] avg_new,
    output logic             primed,
    output logic             accept
);

    localparam int N     = 1 << LOG2_LEN;
    localparam int SUM_W = sum_width(WIDTH, LOG2_LEN);

    logic [WIDTH-1:0]    ring [N];
    logic [LOG2_LEN-1:0] ptr;
    logic [LOG2_LEN:0]   fill;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    sum_next;

    // sum always covers ring[ptr], so the subtraction cannot underflow.
    always_comb begin
        accept   = ivalid & ~clear;
        sum_next = sum + SUM_W'(mag) - SUM_W'(ring[ptr]);
        avg_new  = sum_next[SUM_W-1 -: WIDTH];
        primed   = accept && (fill >= (LOG2_LEN+1)'(N - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) ring[i] <= '0;
            ptr    <= '0;
            fill   <= '0;
            sum    <= '0;
            avg    <= '0;
            ovalid <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) ring[i] <= '0;
            ptr    <= '0;
            fill   <= '0;
            sum    <= '0;
            avg    <= '0;
            ovalid <= 1'b0;
        end else if (accept) begin
            ring[ptr] <= mag;
            ptr       <= ptr + LOG2_LEN'(1);
            sum       <= sum_next;
            if (fill != (LOG2_LEN+1)'(N)) fill <= fill + (LOG2_LEN+1)'(1);
            avg    <= avg_new;
            ovalid <= 1'b1;
        end else begin
            ovalid <= 1'b0;
        end
    end

endmodule

// File: rtl/magnitude_detector.sv
// Signal-present detector: moving-average window plus hysteresis/hold-off FSM.
//   state  | meaning
//   IDLE   | no signal, waiting for a qualifying average
//   ARM    | qualifying run in progress, counting toward hold_cnt
//   ACTIVE | signal present, detect high until avg < thr_off
module magnitude_detector
    import magnitude_detector_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LOG2_LEN = 4,
    parameter int HOLD_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  mag,
    input  logic              ivalid,
    input  logic [WIDTH-1:0]  thr_on,
    input  logic [WIDTH-1:0]  thr_off,
    input  logic [HOLD_W-1:0] hold_cnt,
    input  logic              clear,
    output logic [WIDTH-1:0]  avg,
    output logic              ovalid,
    output logic              detect,
    output logic              det_start,
    output logic              det_end
);

    logic [WIDTH-1:0]  avg_new;
    logic              primed;
    logic              accept;
    det_state_t        state, state_next;
    logic [HOLD_W-1:0] cnt, cnt_next;
    logic              start_next, end_next;

    magnitude_window #(
        .WIDTH   (WIDTH),
        .LOG2_LEN(LOG2_LEN)
    ) u_window (
        .clock  (clock),
        .reset  (reset),
        .mag    (mag),
        .ivalid (ivalid),
        .clear  (clear),
        .avg    (avg),
        .ovalid (ovalid),
        .avg_new(avg_new),
        .primed (primed),
        .accept (accept)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (clear) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (accept && primed) begin
            case (state)
                IDLE: begin
                    if (avg_new >= thr_on) begin
                        if (hold_cnt == '0) begin
                            state_next = ACTIVE;
                        end else begin
                            state_next = ARM;
                            cnt_next   = HOLD_W'(1);
                        end
                    end
                end
                ARM: begin
                    if (avg_new < thr_on) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == hold_cnt) begin
                        state_next = ACTIVE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + HOLD_W'(1);
                    end
                end
                ACTIVE: begin
                    if (avg_new < thr_off) state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
        // Edge pulses cover clear as well, so a flush while ACTIVE reports det_end.
        start_next = (state_next == ACTIVE) && (state != ACTIVE);
        end_next   = (state == ACTIVE) && (state_next != ACTIVE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            det_start <= 1'b0;
            det_end   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            det_start <= start_next;
            det_end   <= end_next;
        end
    end

    assign detect = (state == ACTIVE);

endmodule

// File: doc/magnitude_detector.md
Name: magnitude_detector

Overview:
Downstream consumer of the I/Q modulus stage. It takes the per-sample magnitude stream and smooths it with a 2^LOG2_LEN-sample boxcar moving average. A hysteresis and hold-off state machine then asserts a signal-present flag, with single-cycle start and end pulses. Its output feeds packet and burst gating logic.

Parameters:
WIDTH, 16, width of the magnitude input, the average output and the thresholds (unsigned).
LOG2_LEN, 4, log2 of the averaging window length N (default N=16).
HOLD_W, 8, width of the hold-off count input.

Ports:
clock  input  1  system clock, all logic rising-edge.
reset  input  1  asynchronous, active-low reset.
mag  input  WIDTH  unsigned magnitude sample from the modulus stage.
ivalid  input  1  mag is valid this cycle.
thr_on  input  WIDTH  activation threshold; an average qualifies when avg >= thr_on.
thr_off  input  WIDTH  release threshold; detection releases when avg < thr_off.
hold_cnt  input  HOLD_W  extra consecutive qualifying averages required before asserting detect.
clear  input  1  synchronous flush of window, sum, fill count and FSM.
avg  output  WIDTH  moving-average magnitude.
ovalid  output  1  avg updated this cycle.
detect  output  1  level, high while the FSM is in ACTIVE.
det_start  output  1  one-cycle pulse on entry to ACTIVE.
det_end  output  1  one-cycle pulse on exit from ACTIVE.

Behaviour:
- Reset (async, reset=0): window entries, sum, write pointer, fill count and hold counter go to 0; FSM goes to IDLE; avg, ovalid, detect, det_start and det_end are all 0.
- Window: N-entry register ring plus a write pointer that wraps modulo N.
- On ivalid: sum_next = sum + mag - window[ptr]; then window[ptr] <= mag; ptr <= ptr+1.
- Sum is WIDTH+LOG2_LEN bits and never overflows; all-ones input gives avg = 2^WIDTH-1.
- avg_new = sum_next >> LOG2_LEN (truncating).
- avg and ovalid are registered, so latency is 1 cycle from the ivalid cycle. ovalid pulses once per accepted sample.
- Startup: empty entries hold 0, so avg ramps up. ovalid fires from the first sample.
- Fill counter saturates at N. The window is "primed" when the current sample is the N-th or later.
- FSM updates on the same edge as avg, using avg_new. It evaluates only when the sample is accepted and the window is primed; otherwise state and counter hold.
- Thresholds and hold_cnt are sampled live on each accepted sample.
- FSM state IDLE:
  - avg_new >= thr_on and hold_cnt==0 -> ACTIVE.
  - avg_new >= thr_on otherwise -> ARM, cnt=1.
- FSM state ARM:
  - avg_new < thr_on -> IDLE, cnt=0.
  - else if cnt==hold_cnt -> ACTIVE.
  - else cnt++.
  - Net effect: detect asserts on the (hold_cnt+1)-th consecutive qualifying average.
- FSM state ACTIVE:
  - avg_new < thr_off -> IDLE.
  - Otherwise stay. There is no hold-off on release.
- detect is high in ACTIVE only.
- det_start and det_end are high for exactly the cycle on which detect changes (same cycle as ovalid).
- Thresholds are applied literally with no reordering. If thr_off > thr_on, the FSM may enter and leave ACTIVE on alternating samples.
- clear takes priority over ivalid, and a sample arriving with clear is dropped. On clear:
  - window, sum, ptr, fill and cnt go to 0; avg goes to 0 and ovalid to 0; FSM goes to IDLE.
  - If the FSM was ACTIVE, det_end pulses on that edge.
- Reset asserted mid-operation clears everything immediately with no det_end pulse.

Decomposition:
- Package magnitude_detector_pkg holds:
  - the state enum (IDLE, ARM, ACTIVE);
  - the sum-width constant function (WIDTH+LOG2_LEN).
- Sub-module magnitude_window holds the ring, pointer, running sum, fill/primed flag, clear handling, and the avg/ovalid registers. It exposes avg_new, primed and accept to the FSM in the top level.

Test Plan:
1. Reset and idle: assert reset mid-stream -> avg=0, ovalid=0, detect=0, no pulses; 20 idle cycles with no ivalid -> outputs stay 0.
2. Ramp: after reset, 16 consecutive samples of mag=5 -> avg after sample k = floor(5k/16) (k=1 ->0, k=4 ->1, k=16 ->5); ovalid exactly 1 cycle after each ivalid; mag=65535 x16 -> avg=65535.
3. Detect and release: thr_on=100, thr_off=50, hold_cnt=2; 16 zeros, then mag=200 -> avg 100 on sample 8 (ARM), 112, then 125 on sample 10 -> detect rises with det_start pulse. After 16 samples of 200, feed zeros -> 12th zero gives avg=50 (still ACTIVE); 13th zero gives avg=37 -> det_end pulse, detect=0.
4. Glitch rejected plus wrap-around: thr_on=100, hold_cnt=20; 16 zeros, one mag=2000, then zeros -> avg=125 for 16 samples (ARM), then 0 on the 17th as 2000 leaves the window -> IDLE, detect never asserts.
5. Priming gate: after reset, thr_on=100, hold_cnt=0, mag=4000 stream -> avg=250 on sample 1 but detect stays 0 until sample 16 output (avg=4000), where det_start pulses.
6. Clear: clear while ACTIVE, with ivalid=1 on the same cycle -> det_end pulse, detect=0, avg=0, ovalid=0, sample dropped; next 16 samples re-prime as in scenario 2.
